// File: rtl/cpu_control.sv
// Control unit for the basic CPU datapath: fetches a 9-bit instruction in T0 and
// sequences mv / mvi / add / sub through up to three execute steps (T1..T3).
module cpu_control #(
  parameter int word = 16
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [word-1:0] DIN,
  output logic [9:0]      select,
  output logic [7:0]      Rin,
  output logic            Ain,
  output logic            Gin,
  output logic            AddSub,
  output logic            Done,
  output logic [8:0]      IR
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [9:0] SEL_DIN = 10'b00_0000_0001;
  localparam logic [9:0] SEL_G   = 10'b00_0000_0010;

  state_t     state_reg;
  state_t     state_next;
  logic [8:0] ir_reg;
  logic [8:0] ir_next;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [9:0] sel_rx;
  logic [9:0] sel_ry;
  logic [7:0] rin_rx;

  // Bits above the 9-bit instruction field carry no meaning for this unit.
  logic unused_din_hi;
  assign unused_din_hi = ^DIN[word-1:9];

  assign opcode = ir_reg[8:6];
  assign rx     = ir_reg[5:3];
  assign ry     = ir_reg[2:0];
  assign sel_rx = 10'd4 << rx;
  assign sel_ry = 10'd4 << ry;
  assign rin_rx = 8'd1 << rx;
  assign IR     = ir_reg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= T0;
      ir_reg    <= 9'd0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    select     = 10'd0;
    Rin        = 8'd0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;

    unique case (state_reg)
      T0: begin
        if (Run) begin
          ir_next    = DIN[8:0];
          state_next = T1;
        end
      end

      T1: begin
        state_next = T0;
        case (opcode)
          OP_MV: begin
            select = sel_ry;
            Rin    = rin_rx;
            Done   = 1'b1;
          end
          OP_MVI: begin
            select = SEL_DIN;
            Rin    = rin_rx;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            select     = sel_rx;
            Ain        = 1'b1;
            state_next = T2;
          end
          // Reserved opcodes complete as a one-step NOP.
          default: Done = 1'b1;
        endcase
      end

      T2: begin
        select     = sel_ry;
        Gin        = 1'b1;
        AddSub     = (opcode == OP_SUB);
        state_next = T3;
      end

      T3: begin
        select     = SEL_G;
        Rin        = rin_rx;
        Done       = 1'b1;
        state_next = T0;
      end

      default: state_next = T0;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: instruction-level model expanding each fetched word into
// its list of per-step output vectors, checked every cycle, plus literal checks.
module tb_cpu_control;

  typedef struct packed {
    logic [9:0] sel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
  } outs_t;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Run = 1'b0;
  logic [15:0] DIN = 16'd0;
  logic [9:0]  select;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic [8:0]  IR;

  int n_checks = 0;
  int n_fail   = 0;

  outs_t      exp_q[$];
  logic [8:0] model_ir = 9'd0;

  cpu_control #(.word(16)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .select (select),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done),
    .IR     (IR)
  );

  always #5 Clock = ~Clock;

  function automatic outs_t mk(logic [9:0] s, logic [7:0] r, logic a, logic g, logic as, logic d);
    outs_t o;
    o = '{sel: s, rin: r, ain: a, gin: g, addsub: as, done: d};
    return o;
  endfunction

  function automatic outs_t actual();
    return mk(select, Rin, Ain, Gin, AddSub, Done);
  endfunction

  // Expand one instruction into the output vector of each execute step.
  task automatic expand(input logic [8:0] ir);
    int op, x, y;
    logic [9:0] bus_x, bus_y;
    logic [7:0] dst;
    op = int'(ir[8:6]);
    x  = int'(ir[5:3]);
    y  = int'(ir[2:0]);
    bus_x = 10'd0; bus_x[2 + x] = 1'b1;
    bus_y = 10'd0; bus_y[2 + y] = 1'b1;
    dst   = 8'd0;  dst[x] = 1'b1;
    case (op)
      0: exp_q.push_back(mk(bus_y, dst, 0, 0, 0, 1));
      1: exp_q.push_back(mk(10'h001, dst, 0, 0, 0, 1));
      2, 3: begin
        exp_q.push_back(mk(bus_x, 8'd0, 1, 0, 0, 0));
        exp_q.push_back(mk(bus_y, 8'd0, 0, 1, (op == 3), 0));
        exp_q.push_back(mk(10'h002, dst, 0, 0, 0, 1));
      end
      default: exp_q.push_back(mk(10'd0, 8'd0, 0, 0, 0, 1));
    endcase
  endtask

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      exp_q.delete();
      model_ir = 9'd0;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (Run) begin
      model_ir = DIN[8:0];
      expand(DIN[8:0]);
    end
  end

  // Per-cycle compare against the model, plus structural output rules.
  always @(negedge Clock) begin
    outs_t e, a;
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    a = actual();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t got sel=%h rin=%h ain=%b gin=%b as=%b done=%b want sel=%h rin=%h ain=%b gin=%b as=%b done=%b",
               $time, a.sel, a.rin, a.ain, a.gin, a.addsub, a.done,
               e.sel, e.rin, e.ain, e.gin, e.addsub, e.done);
    end
    n_checks++;
    if (IR !== model_ir) begin
      n_fail++;
      $display("FAIL cycle_ir t=%0t got %h want %h", $time, IR, model_ir);
    end
    n_checks++;
    if ($countones(select) > 1 || $countones(Rin) > 1 ||
        (int'(Ain) + int'(Gin) + int'(|Rin)) > 1) begin
      n_fail++;
      $display("FAIL exclusivity t=%0t got sel=%h rin=%h ain=%b gin=%b want at most one active",
               $time, select, Rin, Ain, Gin);
    end
  end

  task automatic lit(input string name, input logic [9:0] s, input logic [7:0] r,
                     input logic a, input logic g, input logic as, input logic d);
    outs_t e, got;
    e   = mk(s, r, a, g, as, d);
    got = actual();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s got sel=%h rin=%h ain=%b gin=%b as=%b done=%b want sel=%h rin=%h ain=%b gin=%b as=%b done=%b",
               name, got.sel, got.rin, got.ain, got.gin, got.addsub, got.done,
               e.sel, e.rin, e.ain, e.gin, e.addsub, e.done);
    end
  endtask

  task automatic lit_ir(input string name, input logic [8:0] want);
    n_checks++;
    if (IR !== want) begin
      n_fail++;
      $display("FAIL %s got IR=%h want IR=%h", name, IR, want);
    end
  endtask

  // Advance to just after the next falling edge and drive new inputs.
  task automatic drive(input logic r, input logic [15:0] d);
    @(negedge Clock);
    #1;
    Run = r;
    DIN = d;
  endtask

  logic [15:0] prog[8] = '{16'h0058, 16'h00D1, 16'h0093, 16'h0140,
                           16'h0009, 16'h01FF, 16'h0036, 16'h00C0};

  initial begin
    #1;
    lit("reset_outputs", 10'd0, 8'd0, 0, 0, 0, 0);
    lit_ir("reset_ir", 9'h000);
    repeat (2) @(posedge Clock);
    drive(0, 16'd0);
    Resetn = 1'b1;
    repeat (5) drive(0, 16'd0);
    lit_ir("idle_ir_hold", 9'h000);
    lit("idle_outputs", 10'd0, 8'd0, 0, 0, 0, 0);

    // mvi R3,#0xAB
    drive(1, 16'h0058);
    drive(0, 16'h00AB);
    lit("mvi_t1", 10'h001, 8'h08, 0, 0, 0, 1);
    lit_ir("mvi_ir", 9'h058);
    drive(0, 16'd0);
    lit("mvi_after", 10'd0, 8'd0, 0, 0, 0, 0);

    // mv R0,R5
    drive(1, 16'h0005);
    drive(0, 16'd0);
    lit("mv_t1", 10'h080, 8'h01, 0, 0, 0, 1);

    // add R1,R2
    drive(1, 16'h008A);
    drive(0, 16'd0);
    lit("add_t1", 10'h008, 8'h00, 1, 0, 0, 0);
    drive(0, 16'd0);
    lit("add_t2", 10'h010, 8'h00, 0, 1, 0, 0);
    drive(0, 16'd0);
    lit("add_t3", 10'h002, 8'h02, 0, 0, 0, 1);
    drive(0, 16'd0);
    lit("add_after", 10'd0, 8'd0, 0, 0, 0, 0);

    // sub R7,R7
    drive(1, 16'h00FF);
    drive(0, 16'd0);
    lit("sub_t1", 10'h200, 8'h00, 1, 0, 0, 0);
    drive(0, 16'd0);
    lit("sub_t2", 10'h200, 8'h00, 0, 1, 1, 0);
    drive(0, 16'd0);
    lit("sub_t3", 10'h002, 8'h80, 0, 0, 0, 1);

    // Reserved opcode with Run held high, then mv R0,R5 with junk upper bits
    drive(1, 16'h01C0);
    drive(1, 16'hFE05);
    lit("nop_t1", 10'd0, 8'd0, 0, 0, 0, 1);
    lit_ir("nop_ir", 9'h1C0);
    drive(1, 16'hFE05);
    lit("nop_back_t0", 10'd0, 8'd0, 0, 0, 0, 0);
    drive(0, 16'd0);
    lit("hi_bits_mv_t1", 10'h080, 8'h01, 0, 0, 0, 1);
    lit_ir("hi_bits_ir", 9'h005);

    // Asynchronous reset in T2 of an add
    drive(1, 16'h008A);
    drive(0, 16'd0);
    drive(0, 16'd0);
    lit("pre_reset_t2", 10'h010, 8'h00, 0, 1, 0, 0);
    Resetn = 1'b0;
    #1;
    lit("midreset_outputs", 10'd0, 8'd0, 0, 0, 0, 0);
    lit_ir("midreset_ir", 9'h000);
    drive(0, 16'd0);
    Resetn = 1'b1;
    repeat (5) drive(0, 16'd0);
    lit_ir("post_reset_ir", 9'h000);
    drive(1, 16'h0005);
    drive(0, 16'd0);
    lit("post_reset_mv", 10'h080, 8'h01, 0, 0, 0, 1);

    // Back-to-back program with Run held high; the per-cycle model checks it
    for (int i = 0; i < 8; i++) begin
      drive(1, prog[i]);
      while (exp_q.size() > 0) drive(1, prog[i]);
    end
    drive(0, 16'd0);
    repeat (6) drive(0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got no completion want finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
